// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Parallel-to-serial front end for the overlapping Moore sequence detector.
// Words arrive over a valid/ready handshake into a one-word holding register.
// They are shifted out MSB-first, one bit per enabled clock. The holding
// register lets the next word load on the last bit's edge, so consecutive
// words stream with no bubble between them.
//
// Optional feature: define SER_PARITY_EN to append an even-parity bit (^data)
// after the data LSB. word_done then marks the parity bit.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   en           shift enable; when low the bit stream freezes (no valid bits)
//   in_data      word to serialize
//   in_valid     in_data is valid
//   in_ready     holding register empty (combinational, !hold_full)
//   dout         serial bit to the detector din (registered)
//   dout_valid   dout carries a real bit this cycle (registered)
//   word_done    high with the final bit of each word (registered)
//   busy         shifter owes bits or holding register is full
module serial_bit_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int BLW = $clog2(NB + 1);
  localparam logic [BLW-1:0] NB_L = BLW'(NB);

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [NB-1:0]    sh;       // sh[NB-1] is the bit currently on dout
  logic [NB-1:0]    ld_word;  // word as it will be emitted, MSB first
  logic [BLW-1:0]   bits_left; // bits still owed, including the one on dout
  logic             accept;

`ifdef SER_PARITY_EN
  assign ld_word = {hold, ^hold};
`else
  assign ld_word = hold;
`endif

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (bits_left != '0) || hold_full;

  // Accept and load are mutually exclusive: a load needs hold_full, which
  // holds in_ready low, so the two hold_full updates never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_full  <= 1'b0;
      sh         <= '0;
      bits_left  <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      if (en) begin
        word_done <= 1'b0;
        if (bits_left > BLW'(1)) begin
          // Advance: next bit sits just below the current one.
          dout       <= sh[NB-2];
          sh         <= sh << 1;
          bits_left  <= bits_left - BLW'(1);
          dout_valid <= 1'b1;
          word_done  <= (bits_left == BLW'(2));
        end else if (hold_full) begin
          // Load from idle or on the last bit's edge (gapless hand-off).
          sh         <= ld_word;
          dout       <= ld_word[NB-1];
          dout_valid <= 1'b1;
          bits_left  <= NB_L;
          hold_full  <= 1'b0;
        end else begin
          // Drain after the last bit, or stay idle.
          dout_valid <= 1'b0;
          bits_left  <= '0;
        end
      end else begin
        // Frozen: shifter and dout hold so the next enabled edge emits
        // the following bit, never a repeat.
        dout_valid <= 1'b0;
        word_done  <= 1'b0;
      end
    end
  end

endmodule
